// File: rtl/pokey_pkg.sv
// Shared types and constants for the POKEY serial-output transmitter.
package pokey_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    localparam logic SOD_IDLE = 1'b1;

    function automatic int unsigned frame_len(int unsigned data_bits, int unsigned stop_bits);
        return 1 + data_bits + stop_bits;
    endfunction

endpackage

// File: rtl/pokey_serout_tx_if.sv
// CPU write port, bit-rate tick and serial/IRQ outputs of the SEROUT transmitter.
interface pokey_serout_tx_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 bit_tick;
    logic                 force_brk;
    logic                 sod;
    logic                 seror_pls;
    logic                 seroc;
    logic                 busy;

    modport master (
        output wr_en, wr_data, bit_tick, force_brk,
        input  sod, seror_pls, seroc, busy
    );

    modport slave (
        input  wr_en, wr_data, bit_tick, force_brk,
        output sod, seror_pls, seroc, busy
    );

endinterface

// File: rtl/pokey_piso_shreg.sv
// Parallel-load, right-shift, fill-1 register; exposes the LSB it will hold after this edge.
module pokey_piso_shreg #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_val,
    output logic             nxt_bit
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;

    always_comb begin
        d = q;
        if (load) begin
            d = load_val;
        end else if (shift) begin
            d = {1'b1, q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            q <= '1;
        end else begin
            q <= d;
        end
    end

    // Next-state LSB lets the owner register sod in the same cycle the shifter moves.
    assign nxt_bit = d[0];

endmodule

// File: rtl/pokey_serout_tx.sv
// POKEY SEROUT transmitter: double-buffered byte, async framing on sod, SEROR/SEROC IRQ sources.
module pokey_serout_tx
    import pokey_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input logic              clk,
    input logic              nrst,
    pokey_serout_tx_if.slave bus
);

    localparam int unsigned FRAME_LEN = frame_len(DATA_BITS, STOP_BITS);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] buf_q;
    logic                 buf_valid_q, buf_valid_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 sod_q, seror_q, seroc_q;
    logic                 load, shift, nxt_bit;
    logic [FRAME_LEN-1:0] load_val;

    assign load_val = {{STOP_BITS{1'b1}}, buf_q, 1'b0};

    always_comb begin
        load        = 1'b0;
        shift       = 1'b0;
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        if (bus.bit_tick) begin
            case (state_q)
                ST_IDLE: load = buf_valid_q;
                ST_SHIFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        load = buf_valid_q;
                        if (!buf_valid_q) state_d = ST_IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (load) begin
            state_d     = ST_SHIFT;
            buf_valid_d = 1'b0;
        end
        // A write coinciding with a transfer refills the buffer after the old byte leaves.
        if (bus.wr_en) buf_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
            sod_q       <= SOD_IDLE;
            seror_q     <= 1'b0;
            seroc_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            if (bus.wr_en) buf_q <= bus.wr_data;
            if (load) begin
                bit_cnt_q <= '0;
            end else if (shift) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            seror_q <= load;
            sod_q   <= bus.force_brk ? 1'b0 : (state_d == ST_SHIFT) ? nxt_bit : SOD_IDLE;
            seroc_q <= (state_d == ST_IDLE) && !buf_valid_d;
        end
    end

    pokey_piso_shreg #(
        .WIDTH(FRAME_LEN)
    ) u_shreg (
        .clk     (clk),
        .nrst    (nrst),
        .load    (load),
        .shift   (shift),
        .load_val(load_val),
        .nxt_bit (nxt_bit)
    );

    assign bus.sod       = sod_q;
    assign bus.seror_pls = seror_q;
    assign bus.seroc     = seroc_q;
    assign bus.busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_pokey_serout_tx.sv
// Scoreboard bench: frame-level reference model feeds per-cycle and per-frame expectation queues.
module tb_pokey_serout_tx;

    localparam int FL = 1 + 8 + 1;

    typedef struct packed {
        logic sod;
        logic seroc;
        logic busy;
        logic seror;
    } exp_t;

    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_err;

    pokey_serout_tx_if #(.DATA_BITS(8)) bus ();

    pokey_serout_tx #(
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       lvl_q[$];
    logic [7:0] frm_q[$];

    // Reference model: a pending byte plus the frame currently on the line.
    logic [7:0]    m_buf;
    logic          m_valid;
    logic          m_active;
    logic [FL-1:0] m_frame;
    int            m_pos;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic tk, input logic brk,
                        input logic rst);
        exp_t e;
        logic started;
        @(negedge clk);
        nrst          = !rst;
        bus.wr_en     = wr;
        bus.wr_data   = d;
        bus.bit_tick  = tk;
        bus.force_brk = brk;
        started       = 1'b0;
        if (rst) begin
            m_valid  = 1'b0;
            m_active = 1'b0;
            e        = '{sod: 1'b1, seroc: 1'b1, busy: 1'b0, seror: 1'b0};
        end else begin
            if (tk) begin
                if (!m_active || m_pos == FL - 1) begin
                    if (m_valid) begin
                        m_frame  = {1'b1, m_buf, 1'b0};
                        m_pos    = 0;
                        m_active = 1'b1;
                        m_valid  = 1'b0;
                        started  = 1'b1;
                        frm_q.push_back(m_buf);
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_pos++;
                end
            end
            if (wr) begin
                m_buf   = d;
                m_valid = 1'b1;
            end
            e.sod   = brk ? 1'b0 : (m_active ? m_frame[m_pos] : 1'b1);
            e.seroc = !m_active && !m_valid;
            e.busy  = m_active;
            e.seror = started;
        end
        lvl_q.push_back(e);
    endtask

    task automatic tick_every(input int n, input int per, input logic brk);
        repeat (n) begin
            repeat (per - 1) step(1'b0, 8'h00, 1'b0, brk, 1'b0);
            step(1'b0, 8'h00, 1'b1, brk, 1'b0);
        end
    endtask

    // Monitor: per-cycle levels, and a whole-frame check started by each seror_pls.
    logic          collecting;
    logic [7:0]    cur;
    logic [FL-1:0] got_bits;
    logic [FL-1:0] brk_mask;
    int            nbits;

    initial begin
        exp_t e;
        collecting = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (lvl_q.size() > 0) begin
                e = lvl_q.pop_front();
                chk("sod", bus.sod, e.sod);
                chk("seroc", bus.seroc, e.seroc);
                chk("busy", bus.busy, e.busy);
                chk("seror_pls", bus.seror_pls, e.seror);
            end
            if (!nrst) begin
                collecting = 1'b0;
            end else if (bus.seror_pls) begin
                if (collecting) chk("frame_truncated_bits", nbits, FL);
                if (frm_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    collecting = 1'b0;
                end else begin
                    cur         = frm_q.pop_front();
                    got_bits    = '0;
                    brk_mask    = '0;
                    got_bits[0] = bus.sod;
                    brk_mask[0] = bus.force_brk;
                    nbits       = 1;
                    collecting  = 1'b1;
                end
            end else if (collecting && bus.bit_tick) begin
                got_bits[nbits] = bus.sod;
                brk_mask[nbits] = bus.force_brk;
                nbits++;
                if (nbits == FL) begin
                    chk("frame_bits", got_bits, {1'b1, cur, 1'b0} & ~brk_mask);
                    collecting = 1'b0;
                end
            end
        end
    end

    initial begin
        int   mode;
        logic tk, wr, rs, brk_r;
        n_cmp         = 0;
        n_err         = 0;
        nrst          = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.bit_tick  = 1'b0;
        bus.force_brk = 1'b0;
        m_buf         = 8'h00;
        m_valid       = 1'b0;
        m_active      = 1'b0;
        m_frame       = '1;
        m_pos         = 0;
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Single frame, tick every 4 clocks.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick_every(12, 4, 1'b0);
        // Back-to-back frames via a mid-frame write.
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        tick_every(4, 4, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        tick_every(22, 4, 1'b0);
        // Overwrite before transfer.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        tick_every(12, 3, 1'b0);
        // Write and tick in the same idle cycle.
        step(1'b1, 8'h96, 1'b1, 1'b0, 1'b0);
        tick_every(12, 2, 1'b0);
        // Break mid-frame, then break held into idle.
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick_every(3, 4, 1'b0);
        tick_every(2, 4, 1'b1);
        tick_every(8, 4, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Reset mid-frame with the buffer full.
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        tick_every(5, 3, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick_every(15, 2, 1'b0);

        brk_r = 1'b0;
        for (int seg = 0; seg < 15; seg++) begin
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 200; i++) begin
                if (mode == 1) tk = 1'b1;
                else if (mode == 0) tk = ($urandom_range(0, 3) == 0);
                else tk = ($urandom_range(0, 1) == 0);
                wr = ($urandom_range(0, 9) == 0);
                rs = ($urandom_range(0, 599) == 0);
                if (brk_r) brk_r = ($urandom_range(0, 9) != 0);
                else brk_r = ($urandom_range(0, 79) == 0);
                step(wr, 8'($urandom), tk, brk_r, rs);
            end
        end

        repeat (30) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #4;
        chk("level_queue_drained", lvl_q.size(), 0);
        chk("frames_pending", frm_q.size(), 0);
        chk("frame_open", 32'(collecting), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
